// File: rtl/cannon_pkg.sv
// Shared types and defaults for the cannon fire scheduler.
// State encoding, timing defaults and a small popcount helper.
package cannon_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_COOLDOWN,
    S_HALT
  } state_e;

  localparam int unsigned GAP_CYCLES_DEF = 32'd50_350_000;
  localparam int unsigned GAP_STEP_DEF   = 32'd5_000_000;
  localparam int unsigned MIN_GAP_DEF    = 32'd12_587_500;

  function automatic logic [3:0] popcount(
    input logic [7:0] v
  );
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/cannon_fire_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr.
// Registering of the result is left to the parent.
module rr_arbiter #(
  parameter int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  int idx;

  // scan from ptr upward with wrap, first hit wins
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    idx          = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any               = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = W'(idx);
      end
    end
  end

endmodule

// File: rtl/cannon_fire_scheduler.sv
// Fire scheduler: round-robin grants, live-bullet cap, shot gap,
// difficulty ramp, and freeze on game_over.
module cannon_fire_scheduler
  import cannon_pkg::*;
#(
  parameter int          N_CANNONS   = 2,
  parameter int          MAX_LIVE    = 1,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int unsigned GAP_STEP    = GAP_STEP_DEF,
  parameter int unsigned MIN_GAP     = MIN_GAP_DEF,
  parameter int          LEVEL_TICKS = 64,
  parameter int          MAX_LEVEL   = 7,
  localparam int LW = (MAX_LEVEL > 0) ? $clog2(MAX_LEVEL + 1) : 1,
  localparam int PW = (N_CANNONS > 1) ? $clog2(N_CANNONS) : 1,
  localparam int TW = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 game_tick,
  input  logic                 game_over,
  input  logic [N_CANNONS-1:0] fire_req,
  input  logic [N_CANNONS-1:0] bullet_active,
  output logic [N_CANNONS-1:0] fire_grant,
  output logic [LW-1:0]        level,
  output logic                 busy,
  output logic                 halted
);

  state_e               state_q, state_d;
  logic [N_CANNONS-1:0] grant_q, grant_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [31:0]          gap_q, gap_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [LW-1:0]        level_q, level_d;

  logic [3:0]           live;
  logic [31:0]          step_total;
  logic [31:0]          cur_gap;
  logic [N_CANNONS-1:0] arb_onehot;
  logic [PW-1:0]        arb_idx;
  logic                 arb_any;

  rr_arbiter #(.N(N_CANNONS)) u_arb (
    .req          (fire_req),
    .ptr          (rr_q),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx),
    .any          (arb_any)
  );

  assign live = popcount(8'(bullet_active));

  // gap for the current level, clamped to the floor without underflow
  always_comb begin
    step_total = 32'(level_q) * GAP_STEP;
    cur_gap    = MIN_GAP;
    if (GAP_CYCLES > step_total) begin
      if (GAP_CYCLES - step_total > MIN_GAP) begin
        cur_gap = GAP_CYCLES - step_total;
      end
    end
  end

  // difficulty ramp: count ticks into levels, frozen on game_over
  always_comb begin
    tick_d  = tick_q;
    level_d = level_q;
    if (game_tick && !game_over) begin
      if (tick_q == TW'(LEVEL_TICKS - 1)) begin
        tick_d = '0;
        if (level_q != LW'(MAX_LEVEL)) begin
          level_d = level_q + LW'(1);
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  // grant FSM; the IDLE arbitration cycle closes the gap window
  always_comb begin
    state_d = state_q;
    grant_d = '0;
    rr_d    = rr_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (game_over) begin
          state_d = S_HALT;
        end else if (arb_any &&
                     live < 4'(MAX_LIVE)) begin
          grant_d = arb_onehot;
          rr_d    = (arb_idx == PW'(N_CANNONS - 1))
                  ? '0 : arb_idx + PW'(1);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        gap_d   = cur_gap - 32'd1;
        state_d = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (game_over) begin
          gap_d   = '0;
          state_d = S_HALT;
        end else if (gap_q <= 32'd1) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      S_HALT: begin
        gap_d = '0;
        if (!game_over) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      tick_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      tick_q  <= tick_d;
      level_q <= level_d;
    end
  end

  assign fire_grant = grant_q;
  assign level      = level_q;
  assign busy       = (state_q == S_GRANT) ||
                      (state_q == S_COOLDOWN);
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_cannon_fire_scheduler.sv
// Directed bench for cannon_fire_scheduler with an
// edge-indexed reference model checked every cycle.
module tb_cannon_fire_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_tick;
  logic       game_over;
  logic [1:0] fire_req;
  logic [1:0] bullet_active;
  logic [1:0] fire_grant;
  logic [1:0] level;
  logic       busy;
  logic       halted;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  cannon_fire_scheduler #(
    .N_CANNONS   (2),
    .MAX_LIVE    (1),
    .GAP_CYCLES  (10),
    .GAP_STEP    (2),
    .MIN_GAP     (4),
    .LEVEL_TICKS (4),
    .MAX_LEVEL   (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .game_tick     (game_tick),
    .game_over     (game_over),
    .fire_req      (fire_req),
    .bullet_active (bullet_active),
    .fire_grant    (fire_grant),
    .level         (level),
    .busy          (busy),
    .halted        (halted)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // model: edge numbers of the last grant and of the last busy cycle
  int m_n   = 0;
  int m_g   = -1;
  int m_end = -2;
  int m_tk  = 0;
  int m_lvl = 0;
  int m_rr  = 0;
  int m_w   = 0;
  bit m_hlt = 1'b0;

  function automatic int gap_of(input int l);
    int g;
    g = 10 - 2 * l;
    return (g < 4) ? 4 : g;
  endfunction

  task automatic model_step();
    int prev;
    bit found;
    m_n++;
    prev = m_n - 1;
    if (rst) begin
      m_g   = -1;
      m_end = -2;
      m_hlt = 1'b0;
      m_rr  = 0;
      m_tk  = 0;
      m_lvl = 0;
    end else begin
      if (m_hlt) begin
        if (!game_over) m_hlt = 1'b0;
      end else if (m_g >= 0 && prev == m_g) begin
        m_end = m_g + gap_of(m_lvl) - 1;
      end else if (m_g >= 0 && prev > m_g &&
                   prev <= m_end) begin
        if (game_over) begin
          m_hlt = 1'b1;
          m_end = -2;
        end
      end else if (game_over) begin
        m_hlt = 1'b1;
      end else if (fire_req != 2'b00 &&
                   $countones(bullet_active) < 1) begin
        found = 1'b0;
        for (int k = 0; k < 2; k++) begin
          if (!found && fire_req[(m_rr + k) % 2]) begin
            found = 1'b1;
            m_w   = (m_rr + k) % 2;
          end
        end
        m_rr  = (m_w + 1) % 2;
        m_g   = m_n;
        m_end = m_n;
      end
      if (game_tick && !game_over) begin
        m_tk++;
        if (m_tk == 4) begin
          m_tk = 0;
          if (m_lvl < 3) m_lvl++;
        end
      end
    end
  endtask

  // every cycle: advance the model by one edge, then compare
  initial begin
    int eg;
    int eb;
    forever begin
      @(negedge clk);
      model_step();
      eg = (m_g == m_n) ? (1 << m_w) : 0;
      eb = (m_g >= 0 && m_n >= m_g && m_n <= m_end) ? 1 : 0;
      chk("m_grant",  32'(fire_grant), 32'(eg));
      chk("m_level",  32'(level),      32'(m_lvl));
      chk("m_busy",   32'(busy),       32'(eb));
      chk("m_halted", 32'(halted),     32'(m_hlt));
    end
  end

  task automatic wait_grant(output int at,
                            output logic [1:0] gv);
    at = -1;
    gv = 2'b00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fire_grant != 2'b00) begin
        at = cyc;
        gv = fire_grant;
        break;
      end
    end
    if (at < 0) chk("grant_timeout", 0, 1);
    #1;
  endtask

  task automatic idle_cycles(input int k, output int ng);
    ng = 0;
    repeat (k) begin
      @(negedge clk);
      if (fire_grant != 2'b00) ng++;
    end
    #1;
  endtask

  task automatic ticks(input int k, output int ng);
    ng = 0;
    repeat (k) begin
      game_tick = 1'b1;
      @(negedge clk);
      if (fire_grant != 2'b00) ng++;
      #1;
      game_tick = 1'b0;
      @(negedge clk);
      if (fire_grant != 2'b00) ng++;
      #1;
    end
  endtask

  initial begin
    int         ta, tb, tc, tnow, ng;
    logic [1:0] g;
    logic [1:0] rr_ids [3];
    rr_ids = '{2'b10, 2'b01, 2'b10};

    rst           = 1'b1;
    game_tick     = 1'b0;
    game_over     = 1'b0;
    fire_req      = 2'b00;
    bullet_active = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant",  32'(fire_grant), 0);
    chk("rst_level",  32'(level),      0);
    chk("rst_busy",   32'(busy),       0);
    chk("rst_halted", 32'(halted),     0);

    // single requester: latency 1, one-cycle pulse, spacing 11
    rst      = 1'b0;
    fire_req = 2'b01;
    tnow     = cyc;
    wait_grant(ta, g);
    chk("t1_latency", 32'(ta - tnow), 1);
    chk("t1_id",      32'(g),         32'b01);
    @(negedge clk);
    chk("t1_pulse",   32'(fire_grant), 0);
    #1;
    wait_grant(tb, g);
    chk("t1_spacing", 32'(tb - ta), 11);
    chk("t1_id2",     32'(g),       32'b01);

    // both requesting: pointer sits at 1, so 10,01,10
    fire_req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      ta = tb;
      wait_grant(tb, g);
      chk("rr_spacing", 32'(tb - ta), 11);
      chk("rr_id",      32'(g),       32'(rr_ids[i]));
    end

    // live cap blocks, release grants next cycle
    fire_req      = 2'b01;
    bullet_active = 2'b10;
    idle_cycles(50, ng);
    chk("cap_nogrant", 32'(ng), 0);
    bullet_active = 2'b00;
    tnow          = cyc;
    wait_grant(ta, g);
    chk("cap_latency", 32'(ta - tnow), 1);
    chk("cap_id",      32'(g),         32'b01);

    // halt during cooldown, ticks frozen, resume
    wait_grant(tb, g);
    chk("h_spacing", 32'(tb - ta), 11);
    @(negedge clk);
    #1;
    game_over = 1'b1;
    fire_req  = 2'b10;
    @(negedge clk);
    chk("h_halted", 32'(halted), 1);
    chk("h_busy",   32'(busy),   0);
    #1;
    ticks(8, ng);
    chk("h_nogrant", 32'(ng),     0);
    chk("h_level",   32'(level),  0);
    chk("h_still",   32'(halted), 1);
    game_over = 1'b0;
    tnow      = cyc;
    wait_grant(ta, g);
    chk("h_resume", 32'(ta - tnow), 2);
    chk("h_id",     32'(g),         32'b10);

    // level ramp shortens the gap, saturating at 3
    fire_req = 2'b11;
    ticks(4, ng);
    chk("lv1", 32'(level), 1);
    wait_grant(tb, g);
    chk("lv0_spacing", 32'(tb - ta), 11);
    wait_grant(tc, g);
    chk("lv1_spacing", 32'(tc - tb), 9);
    ticks(12, ng);
    chk("lv3", 32'(level), 3);
    wait_grant(ta, g);
    wait_grant(tb, g);
    chk("lv3_spacing", 32'(tb - ta), 5);
    ticks(4, ng);
    chk("lv_sat", 32'(level), 3);
    wait_grant(ta, g);
    wait_grant(tb, g);
    chk("sat_spacing", 32'(tb - ta), 5);

    // reset in cooldown at level 2
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    ticks(8, ng);
    chk("r_lv2", 32'(level), 2);
    wait_grant(ta, g);
    @(negedge clk);
    chk("r_cool_busy", 32'(busy), 1);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("r_level",  32'(level),      0);
    chk("r_busy",   32'(busy),       0);
    chk("r_grant",  32'(fire_grant), 0);
    chk("r_halted", 32'(halted),     0);
    #1;
    rst  = 1'b0;
    tnow = cyc;
    wait_grant(ta, g);
    chk("r_latency", 32'(ta - tnow), 1);
    chk("r_id",      32'(g),         32'b01);

    fire_req = 2'b00;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
